// File: rtl/ariane_pkg.sv
// ariane_pkg: shared issue-throttle FSM states and default history/threshold constants
package ariane_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        THROTTLE = 2'd1,
        COOLDOWN = 2'd2
    } throttle_state_t;

    localparam int LS_HIST_LEN        = 14;
    localparam int LS_THROTTLE_THRESH = 8;

endpackage

// File: rtl/ls_hist_tracker.sv
// ls_hist_tracker: shift-register history of accepted instruction classes with incremental popcount
module ls_hist_tracker #(
    parameter int HIST_LEN = 14,
    parameter int DW       = $clog2(HIST_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic                ack_i,
    input  logic                is_ls_i,
    output logic [HIST_LEN-1:0] hist_o,
    output logic [DW-1:0]       density_o
);

    logic                acc;
    logic [HIST_LEN-1:0] hist_q, hist_d;
    logic [DW-1:0]       density_q, density_d;

    assign acc = valid_i & ack_i & ~flush_i;

    // The popped bit is always counted in density, so the subtraction cannot underflow.
    always_comb begin
        hist_d    = acc ? {is_ls_i, hist_q[HIST_LEN-1:1]} : hist_q;
        density_d = acc ? density_q + DW'(is_ls_i) - DW'(hist_q[0]) : density_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q    <= '0;
            density_q <= '0;
        end else begin
            hist_q    <= hist_d;
            density_q <= density_d;
        end
    end

    assign hist_o    = hist_q;
    assign density_o = density_q;

endmodule

// File: rtl/issue_throttle_ctrl.sv
// issue_throttle_ctrl: withholds LS issue under high LS density and LSU back-pressure; ISSUE_THROTTLE_PERF_EN enables the stall counter
module issue_throttle_ctrl
    import ariane_pkg::*;
#(
    parameter int HIST_LEN    = LS_HIST_LEN,
    parameter int LS_THRESH   = LS_THROTTLE_THRESH,
    parameter int HOLD_CYCLES = 4,
    parameter int DW          = $clog2(HIST_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                instr_valid_i,
    input  logic                instr_is_ls_i,
    input  logic                instr_ack_i,
    input  logic                lsu_ready_i,
    output logic                valid_o,
    output logic                throttle_o,
    output logic [DW-1:0]       ls_density_o,
    output logic [HIST_LEN-1:0] ls_hist_o,
    output logic [31:0]         throttle_cycles_o
);

    localparam int            HW        = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HOLD_CYCLES > 0 ? HW'(HOLD_CYCLES - 1) : '0;

    throttle_state_t state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    assign throttle_o = state_q != RUN;
    assign valid_o    = instr_valid_i & ~(instr_is_ls_i & throttle_o);

    ls_hist_tracker #(
        .HIST_LEN (HIST_LEN),
        .DW       (DW)
    ) i_ls_hist_tracker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .valid_i   (valid_o),
        .ack_i     (instr_ack_i),
        .is_ls_i   (instr_is_ls_i),
        .hist_o    (ls_hist_o),
        .density_o (ls_density_o)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            RUN: if (ls_density_o >= DW'(LS_THRESH) && !lsu_ready_i) state_d = THROTTLE;
            THROTTLE: if (lsu_ready_i) begin
                state_d    = HOLD_CYCLES == 0 ? RUN : COOLDOWN;
                hold_cnt_d = HOLD_INIT;
            end
            COOLDOWN: begin
                if (!lsu_ready_i) state_d = THROTTLE;
                else if (hold_cnt_q == '0) state_d = RUN;
                else hold_cnt_d = hold_cnt_q - HW'(1);
            end
            default: state_d = RUN;
        endcase
        if (flush_i) begin
            state_d    = RUN;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef ISSUE_THROTTLE_PERF_EN
    logic [31:0] perf_q, perf_d;

    assign perf_d = (throttle_o && instr_valid_i && instr_is_ls_i && perf_q != '1) ? perf_q + 32'd1 : perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) perf_q <= '0;
        else perf_q <= perf_d;
    end

    assign throttle_cycles_o = perf_q;
`else
    assign throttle_cycles_o = '0;
`endif

endmodule

// File: tb/tb_issue_throttle_ctrl.sv
// tb_issue_throttle_ctrl: directed self-checking bench for issue_throttle_ctrl with default parameters
module tb_issue_throttle_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_is_ls_i = 1'b0;
    logic        instr_ack_i = 1'b0;
    logic        lsu_ready_i = 1'b1;
    logic        valid_o;
    logic        throttle_o;
    logic [3:0]  ls_density_o;
    logic [13:0] ls_hist_o;
    logic [31:0] throttle_cycles_o;

    int n_chk = 0;
    int n_fail = 0;

`ifdef ISSUE_THROTTLE_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd10;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    always #5 clk = ~clk;

    issue_throttle_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .instr_valid_i     (instr_valid_i),
        .instr_is_ls_i     (instr_is_ls_i),
        .instr_ack_i       (instr_ack_i),
        .lsu_ready_i       (lsu_ready_i),
        .valid_o           (valid_o),
        .throttle_o        (throttle_o),
        .ls_density_o      (ls_density_o),
        .ls_hist_o         (ls_hist_o),
        .throttle_cycles_o (throttle_cycles_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst_i = 1'b0;
        chk("rst_throttle", 32'(throttle_o), 32'd0);
        chk("rst_density", 32'(ls_density_o), 32'd0);
        chk("rst_hist", 32'(ls_hist_o), 32'd0);
        chk("rst_perf", throttle_cycles_o, 32'd0);
        instr_valid_i = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd1);

        instr_is_ls_i = 1'b1;
        instr_ack_i   = 1'b1;
        lsu_ready_i   = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk("fill_valid", 32'(valid_o), 32'd1);
            chk("fill_throttle", 32'(throttle_o), 32'd0);
            step();
        end
        chk("fill_density", 32'(ls_density_o), 32'd14);
        chk("fill_hist", 32'(ls_hist_o), 32'h3FFF);
        step();
        chk("full_push_density", 32'(ls_density_o), 32'd14);

        do_reset();
        chk("rst2_density", 32'(ls_density_o), 32'd0);
        repeat (8) step();
        chk("d8_density", 32'(ls_density_o), 32'd8);
        chk("d8_hist", 32'(ls_hist_o), 32'h3FC0);
        instr_ack_i = 1'b0;
        lsu_ready_i = 1'b0;
        #1;
        chk("pre_thr_valid", 32'(valid_o), 32'd1);
        chk("pre_thr_throttle", 32'(throttle_o), 32'd0);
        step();
        chk("thr_throttle", 32'(throttle_o), 32'd1);
        chk("thr_valid_ls", 32'(valid_o), 32'd0);
        instr_is_ls_i = 1'b0;
        #1;
        chk("thr_valid_nonls", 32'(valid_o), 32'd1);
        instr_is_ls_i = 1'b1;
        lsu_ready_i   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("recover_throttle", 32'(throttle_o), 32'(i < 5));
        end

        lsu_ready_i = 1'b0;
        step();
        chk("relapse_enter", 32'(throttle_o), 32'd1);
        lsu_ready_i = 1'b1;
        step();
        step();
        chk("cooldown_valid_ls", 32'(valid_o), 32'd0);
        lsu_ready_i = 1'b0;
        step();
        chk("relapse_throttle", 32'(throttle_o), 32'd1);
        lsu_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("relapse_recover", 32'(throttle_o), 32'(i < 5));
        end

        lsu_ready_i = 1'b0;
        step();
        chk("flush_pre_throttle", 32'(throttle_o), 32'd1);
        flush_i       = 1'b1;
        instr_ack_i   = 1'b1;
        instr_is_ls_i = 1'b0;
        step();
        chk("flush_throttle", 32'(throttle_o), 32'd0);
        chk("flush_hist", 32'(ls_hist_o), 32'h3FC0);
        chk("flush_density", 32'(ls_density_o), 32'd8);
        flush_i       = 1'b0;
        instr_ack_i   = 1'b0;
        instr_is_ls_i = 1'b1;
        step();
        chk("post_flush_throttle", 32'(throttle_o), 32'd1);

        do_reset();
        instr_ack_i = 1'b1;
        lsu_ready_i = 1'b0;
        for (int i = 0; i < 28; i++) begin
            instr_is_ls_i = (i % 2) == 0;
            step();
            chk("alt_throttle", 32'(throttle_o), 32'd0);
        end
        chk("alt_density", 32'(ls_density_o), 32'd7);
        chk("alt_hist", 32'(ls_hist_o), 32'h1555);
        instr_is_ls_i = 1'b1;
        step();
        chk("alt_ls_pop_ls", 32'(ls_density_o), 32'd7);
        chk("alt_ls_hist", 32'(ls_hist_o), 32'h2AAA);
        step();
        chk("alt_ls_pop_n", 32'(ls_density_o), 32'd8);
        chk("alt_lag_throttle", 32'(throttle_o), 32'd0);
        instr_ack_i = 1'b0;
        step();
        chk("alt_thresh_throttle", 32'(throttle_o), 32'd1);

        do_reset();
        instr_ack_i = 1'b1;
        lsu_ready_i = 1'b1;
        repeat (8) step();
        instr_ack_i = 1'b0;
        lsu_ready_i = 1'b0;
        step();
        chk("perf_enter", 32'(throttle_o), 32'd1);
        chk("perf_zero", throttle_cycles_o, 32'd0);
        repeat (10) step();
        chk("perf_count", throttle_cycles_o, PERF_EXP);
        instr_is_ls_i = 1'b0;
        repeat (2) step();
        chk("perf_nonls_hold", throttle_cycles_o, PERF_EXP);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("perf_flush_keep", throttle_cycles_o, PERF_EXP);

        rst_i       = 1'b1;
        flush_i     = 1'b1;
        instr_ack_i = 1'b1;
        step();
        rst_i       = 1'b0;
        flush_i     = 1'b0;
        instr_ack_i = 1'b0;
        chk("rst_win_density", 32'(ls_density_o), 32'd0);
        chk("rst_win_hist", 32'(ls_hist_o), 32'd0);
        chk("rst_win_perf", throttle_cycles_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
